// File: rtl/vend_coin_sched.sv
// vend_coin_sched: round-robin scheduler sharing the vending FSM money input among N_SLOTS coin acceptors
// Each slot has a 1-entry buffer; coins are issued as 1-cycle pulses separated by GAP_CYCLES idle cycles.
module vend_coin_sched #(
    parameter int N_SLOTS    = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_SLOTS-1:0]     coin_valid,
    input  logic [2*N_SLOTS-1:0]   coin_code,
    output logic [N_SLOTS-1:0]     coin_ready,
    input  logic [2:0]             vm_state,
    output logic [2:0]             money,
    output logic [N_SLOTS-1:0]     grant_slot,
    output logic                   bad_coin,
    output logic [CNT_W-1:0]       coins_issued,
    output logic                   busy
);
    localparam int PW = $clog2(N_SLOTS);
    localparam logic [2:0] RET_CHANGE = 3'b101;
    typedef enum logic {IDLE, GAP} state_t;
    state_t state, state_nx;
    logic [N_SLOTS-1:0] full, accept, nz, load, win_oh;
    logic [2*N_SLOTS-1:0] buf_code;
    logic [PW-1:0] rr, win;
    logic [3:0] gap_cnt;
    logic found, issue;
    for (genvar i = 0; i < N_SLOTS; i++) begin : g_nz
        assign nz[i] = |coin_code[2*i +: 2];
    end
    assign coin_ready = ~full;
    assign accept = coin_valid & coin_ready;
    assign load = accept & nz;
    assign busy = |full | (state != IDLE);
    // first full slot at or after rr, wrapping to the lowest full slot below rr
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLOTS; i++)
            if (!found && full[i] && PW'(i) >= rr) begin
                win = PW'(i);
                found = 1'b1;
            end
        for (int i = 0; i < N_SLOTS; i++)
            if (!found && full[i]) begin
                win = PW'(i);
                found = 1'b1;
            end
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    always_comb state_nx = (state == IDLE) ? (issue ? GAP : IDLE) : (gap_cnt == 4'd1 ? IDLE : GAP);
    always_comb begin
        issue = (state == IDLE) && en && (vm_state != RET_CHANGE) && found;
        win_oh = issue ? N_SLOTS'(1) << win : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            buf_code <= '0;
            rr <= '0;
            gap_cnt <= '0;
            money <= '0;
            grant_slot <= '0;
            bad_coin <= 1'b0;
            coins_issued <= '0;
        end else begin
            full <= (full & ~win_oh) | load;
            for (int i = 0; i < N_SLOTS; i++)
                if (load[i]) buf_code[2*i +: 2] <= coin_code[2*i +: 2];
            bad_coin <= |(accept & ~nz);
            money <= issue ? {1'b0, buf_code[{win, 1'b0} +: 2]} : 3'b000;
            grant_slot <= win_oh;
            if (issue) begin
                rr <= (win == PW'(N_SLOTS - 1)) ? '0 : win + 1'b1;
                coins_issued <= &coins_issued ? coins_issued : coins_issued + 1'b1;
                gap_cnt <= 4'(GAP_CYCLES);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vend_coin_sched.sv
// tb_vend_coin_sched: scenario tasks plus randomized run against a cycle-level behavioural model
module tb_vend_coin_sched;
    localparam int N = 4, GAP = 1, CW = 16, SW = 3;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [N-1:0] coin_valid = '0;
    logic [2*N-1:0] coin_code = '0;
    logic [2:0] vm_state = '0;
    logic [N-1:0] coin_ready, grant_slot, s_ready, s_grant;
    logic [2:0] money, s_money;
    logic bad_coin, busy, s_bad, s_busy;
    logic [CW-1:0] coins_issued;
    logic [SW-1:0] s_count;
    int n_cmp = 0, n_bad = 0;
    bit m_full[N];
    logic [1:0] m_code[N];
    logic [N-1:0] m_acc, e_grant;
    logic [2:0] e_money;
    logic e_bad;
    int m_rr = 0, m_last = -100, cyc = 0, m_cnt = 0;

    vend_coin_sched #(.N_SLOTS(N), .GAP_CYCLES(GAP), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .en(en), .coin_valid(coin_valid), .coin_code(coin_code),
        .coin_ready(coin_ready), .vm_state(vm_state), .money(money), .grant_slot(grant_slot),
        .bad_coin(bad_coin), .coins_issued(coins_issued), .busy(busy));
    vend_coin_sched #(.N_SLOTS(N), .GAP_CYCLES(GAP), .CNT_W(SW)) u_sat (
        .clk(clk), .rst(rst), .en(en), .coin_valid(coin_valid), .coin_code(coin_code),
        .coin_ready(s_ready), .vm_state(vm_state), .money(s_money), .grant_slot(s_grant),
        .bad_coin(s_bad), .coins_issued(s_count), .busy(s_busy));

    always #5 clk = ~clk;

    // Model: issue allowed once more than GAP edges have passed since the last issue.
    task automatic tick();
        int w;
        w = -1;
        if (rst) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
            m_rr = 0; m_last = -100; m_cnt = 0;
            e_money = '0; e_grant = '0; e_bad = 0; m_acc = '0;
        end else begin
            e_bad = 0; m_acc = '0; e_money = '0; e_grant = '0;
            for (int i = 0; i < N; i++)
                if (coin_valid[i] && !m_full[i]) begin
                    m_acc[i] = 1'b1;
                    if (coin_code[2*i +: 2] == 2'b00) e_bad = 1;
                end
            if (en && vm_state != 3'b101 && cyc - m_last > GAP)
                for (int k = 0; k < N; k++)
                    if (w < 0 && m_full[(m_rr + k) % N]) w = (m_rr + k) % N;
            if (w >= 0) begin
                e_money = {1'b0, m_code[w]};
                e_grant = N'(1) << w;
                m_full[w] = 0;
                m_rr = (w + 1) % N;
                m_last = cyc;
                m_cnt++;
            end
            for (int i = 0; i < N; i++)
                if (m_acc[i] && coin_code[2*i +: 2] != 2'b00) begin
                    m_full[i] = 1;
                    m_code[i] = coin_code[2*i +: 2];
                end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; coin_valid = '0; vm_state = '0;
        tick();
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; coin_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (money !== 3'b000) begin n_bad++; $display("FAIL reset_money: got %0h want 0", money); end
        n_cmp++; if (grant_slot !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %0h want 0", grant_slot); end
        n_cmp++; if (bad_coin !== 1'b0) begin n_bad++; $display("FAIL reset_bad: got %0h want 0", bad_coin); end
        n_cmp++; if (coin_ready !== 4'b1111) begin n_bad++; $display("FAIL reset_ready: got %0h want f", coin_ready); end
        n_cmp++; if (coins_issued !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0h want 0", coins_issued); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0h want 0", busy); end
    endtask

    task automatic test_single();
        coin_valid = 4'b0001; coin_code = 8'b00_00_00_01;
        tick();
        coin_valid = '0;
        n_cmp++; if (coin_ready !== 4'b1110) begin n_bad++; $display("FAIL single_ready: got %0h want e", coin_ready); end
        n_cmp++; if (money !== 3'b000) begin n_bad++; $display("FAIL single_early: got %0h want 0", money); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %0h want 1", busy); end
        tick();
        n_cmp++; if (money !== 3'b001) begin n_bad++; $display("FAIL single_money: got %0h want 1", money); end
        n_cmp++; if (grant_slot !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %0h want 1", grant_slot); end
        n_cmp++; if (coins_issued !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0h want 1", coins_issued); end
        tick();
        n_cmp++; if (money !== 3'b000 || grant_slot !== 4'b0000) begin n_bad++; $display("FAIL single_gap: got %0h/%0h want 0/0", money, grant_slot); end
        n_cmp++; if (coin_ready !== 4'b1111) begin n_bad++; $display("FAIL single_ready2: got %0h want f", coin_ready); end
    endtask

    task automatic test_all_slots();
        int exp_slot[5] = '{0, 1, 2, 3, 0};
        logic [2:0] exp_money[5] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2};
        do_reset();
        coin_valid = 4'b1111; coin_code = 8'b01_11_10_01;
        tick();
        coin_valid = '0;
        n_cmp++; if (coin_ready !== 4'b0000) begin n_bad++; $display("FAIL all_ready: got %0h want 0", coin_ready); end
        for (int j = 0; j < 5; j++) begin
            tick();
            n_cmp++; if (money !== exp_money[j]) begin n_bad++; $display("FAIL all_money[%0d]: got %0h want %0h", j, money, exp_money[j]); end
            n_cmp++; if (grant_slot !== N'(1) << exp_slot[j]) begin n_bad++; $display("FAIL all_grant[%0d]: got %0h want %0h", j, grant_slot, N'(1) << exp_slot[j]); end
            if (j == 0) begin coin_valid = 4'b0001; coin_code[1:0] = 2'b10; end
            tick();
            coin_valid = '0;
            n_cmp++; if (money !== 3'b000) begin n_bad++; $display("FAIL all_gap[%0d]: got %0h want 0", j, money); end
        end
        n_cmp++; if (coins_issued !== 16'd5) begin n_bad++; $display("FAIL all_count: got %0h want 5", coins_issued); end
    endtask

    task automatic test_return_state();
        vm_state = 3'b101; coin_valid = 4'b0100; coin_code[5:4] = 2'b11;
        tick();
        coin_valid = '0;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++; if (money !== 3'b000 || grant_slot !== 4'b0000) begin n_bad++; $display("FAIL ret_hold[%0d]: got %0h/%0h want 0/0", j, money, grant_slot); end
        end
        n_cmp++; if (coin_ready[2] !== 1'b0) begin n_bad++; $display("FAIL ret_ready: got %0h want 0", coin_ready[2]); end
        vm_state = 3'b000;
        tick();
        n_cmp++; if (money !== 3'b011) begin n_bad++; $display("FAIL ret_money: got %0h want 3", money); end
        n_cmp++; if (grant_slot !== 4'b0100) begin n_bad++; $display("FAIL ret_grant: got %0h want 4", grant_slot); end
        tick();
    endtask

    task automatic test_bad_coin();
        int cnt;
        cnt = m_cnt;
        coin_valid = 4'b0010; coin_code[3:2] = 2'b00;
        tick();
        coin_valid = '0;
        n_cmp++; if (bad_coin !== 1'b1) begin n_bad++; $display("FAIL bad_pulse: got %0h want 1", bad_coin); end
        n_cmp++; if (coin_ready[1] !== 1'b1) begin n_bad++; $display("FAIL bad_ready: got %0h want 1", coin_ready[1]); end
        n_cmp++; if (money !== 3'b000) begin n_bad++; $display("FAIL bad_money: got %0h want 0", money); end
        n_cmp++; if (coins_issued !== CW'(cnt)) begin n_bad++; $display("FAIL bad_count: got %0h want %0h", coins_issued, cnt); end
        tick();
        n_cmp++; if (bad_coin !== 1'b0) begin n_bad++; $display("FAIL bad_once: got %0h want 0", bad_coin); end
        n_cmp++; if (money !== 3'b000 || busy !== 1'b0) begin n_bad++; $display("FAIL bad_idle: got %0h/%0h want 0/0", money, busy); end
    endtask

    task automatic test_en_hold();
        do_reset();
        en = 1'b0; coin_valid = 4'b1001; coin_code = 8'b10_00_00_01;
        tick();
        coin_valid = '0;
        for (int j = 0; j < 5; j++) begin
            tick();
            n_cmp++; if (money !== 3'b000) begin n_bad++; $display("FAIL en_money[%0d]: got %0h want 0", j, money); end
            n_cmp++; if (coin_ready !== 4'b0110) begin n_bad++; $display("FAIL en_ready[%0d]: got %0h want 6", j, coin_ready); end
        end
        en = 1'b1;
        tick();
        n_cmp++; if (grant_slot !== 4'b0001 || money !== 3'b001) begin n_bad++; $display("FAIL en_first: got %0h/%0h want 1/1", grant_slot, money); end
        tick();
        tick();
        n_cmp++; if (grant_slot !== 4'b1000 || money !== 3'b010) begin n_bad++; $display("FAIL en_second: got %0h/%0h want 8/2", grant_slot, money); end
    endtask

    task automatic test_reset_mid_gap();
        do_reset();
        coin_valid = 4'b0111; coin_code = 8'b00_11_10_01;
        tick();
        coin_valid = '0;
        tick();
        n_cmp++; if (money !== 3'b001 || coin_ready !== 4'b1001) begin n_bad++; $display("FAIL mid_pre: got %0h/%0h want 1/9", money, coin_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (money !== 3'b000 || grant_slot !== 4'b0000 || bad_coin !== 1'b0) begin n_bad++; $display("FAIL mid_out: got %0h/%0h/%0h want 0/0/0", money, grant_slot, bad_coin); end
        n_cmp++; if (coin_ready !== 4'b1111 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %0h/%0h want f/0", coin_ready, busy); end
        n_cmp++; if (coins_issued !== 16'd0) begin n_bad++; $display("FAIL mid_count: got %0h want 0", coins_issued); end
        tick();
        tick();
        n_cmp++; if (money !== 3'b000) begin n_bad++; $display("FAIL mid_discard: got %0h want 0", money); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            coin_valid = 4'b0001; coin_code[1:0] = 2'b01;
            tick();
            coin_valid = '0;
            tick();
            tick();
            n_cmp++; if (s_count !== SW'(n > 7 ? 7 : n)) begin n_bad++; $display("FAIL sat_small[%0d]: got %0h want %0h", n, s_count, n > 7 ? 7 : n); end
            n_cmp++; if (coins_issued !== CW'(n)) begin n_bad++; $display("FAIL sat_wide[%0d]: got %0h want %0h", n, coins_issued, n); end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_ready;
        logic exp_busy;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            en = $urandom_range(0, 9) != 0;
            vm_state = ($urandom_range(0, 5) == 0) ? 3'b101 : 3'($urandom_range(0, 4));
            for (int i = 0; i < N; i++)
                if (!coin_valid[i] && $urandom_range(0, 3) == 0) begin
                    coin_valid[i] = 1'b1;
                    coin_code[2*i +: 2] = 2'($urandom_range(0, 3));
                end
            tick();
            coin_valid = coin_valid & ~m_acc;
            exp_busy = cyc - m_last <= GAP;
            for (int i = 0; i < N; i++) begin
                exp_ready[i] = !m_full[i];
                if (m_full[i]) exp_busy = 1'b1;
            end
            n_cmp++; if (money !== e_money) begin n_bad++; $display("FAIL rnd_money@%0d: got %0h want %0h", c, money, e_money); end
            n_cmp++; if (grant_slot !== e_grant) begin n_bad++; $display("FAIL rnd_grant@%0d: got %0h want %0h", c, grant_slot, e_grant); end
            n_cmp++; if (bad_coin !== e_bad) begin n_bad++; $display("FAIL rnd_bad@%0d: got %0h want %0h", c, bad_coin, e_bad); end
            n_cmp++; if (coin_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready@%0d: got %0h want %0h", c, coin_ready, exp_ready); end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy@%0d: got %0h want %0h", c, busy, exp_busy); end
            n_cmp++; if (coins_issued !== CW'(m_cnt)) begin n_bad++; $display("FAIL rnd_count@%0d: got %0h want %0h", c, coins_issued, m_cnt); end
            n_cmp++; if (s_count !== SW'(m_cnt > 7 ? 7 : m_cnt)) begin n_bad++; $display("FAIL rnd_sat@%0d: got %0h want %0h", c, s_count, m_cnt > 7 ? 7 : m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_slots();
        test_return_state();
        test_bad_coin();
        test_en_hold();
        test_reset_mid_gap();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
